// File: rtl/string_detector_ctrl.sv
// string_detector_ctrl
// Session controller and serial pattern matcher. A start request in IDLE
// latches the pattern, frame length and overlap mode, then RUN shifts in
// frame_len qualified bits and counts occurrences of the pattern. DONE
// pulses for one cycle; the count and overflow flag hold until the next
// accepted start.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        session request, honoured only in IDLE
//   pattern      target pattern, MSB is the first bit received
//   frame_len    number of valid bits in the session (0 = empty session)
//   overlap_en   1 = overlapping matches counted, 0 = non-overlapping
//   bit_in       serial data bit
//   bit_valid    bit_in qualifier, sampled only in RUN
//   busy         high while in RUN
//   done         one-cycle completion pulse
//   match_pulse  one-cycle pulse for each match-completing bit
//   N            saturating match count
//   overflow     sticky, set on an increment attempt with N at all-ones
module string_detector_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             overlap_en,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             match_pulse,
  output logic [CNT_W-1:0] N,
  output logic             overflow
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [PAT_W-2:0]   sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [LEN_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mp_q, mp_d;

  logic [PAT_W-1:0]   window;
  logic [LEN_W-1:0]   bcnt_inc;
  logic               hit;

  assign window   = {sr_q, bit_in};
  assign bcnt_inc = bcnt_q + 1'b1;
  // The fill counter gates matches until a full pattern's worth of bits
  // has arrived since session start (or since the last match when
  // overlapping is disabled).
  assign hit      = (window == pat_q) && (fill_q >= FILL_W'(PAT_W - 1));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    bcnt_d  = bcnt_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    mp_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          len_d   = frame_len;
          ovl_d   = overlap_en;
          sr_d    = '0;
          fill_d  = '0;
          bcnt_d  = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
          state_d = (frame_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bit_valid) begin
          sr_d   = window[PAT_W-2:0];
          bcnt_d = bcnt_inc;
          fill_d = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
          if (hit) begin
            mp_d = 1'b1;
            if (n_q == '1) begin
              ovf_d = 1'b1;
            end else begin
              n_d = n_q + 1'b1;
            end
            if (!ovl_q) begin
              fill_d = '0;
            end
          end
          if (bcnt_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy/done are registered images of the next state so they line up
    // with the state register rather than lagging it by a cycle.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      sr_q    <= '0;
      fill_q  <= '0;
      bcnt_q  <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      bcnt_q  <= bcnt_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mp_q    <= mp_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign match_pulse = mp_q;
  assign N           = n_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_string_detector_ctrl.sv
// Scoreboard bench for string_detector_ctrl: stimulus pushes hand-derived
// match/done events (cycle stamp, N, overflow) into a queue; a negedge
// monitor pops and compares whenever match_pulse or done is observed.
module tb_string_detector_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] frame_len = '0;
  logic       overlap_en = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       busy, done, match_pulse, overflow;
  logic [3:0] N;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit          is_done;
    int unsigned cyc;
    logic [3:0]  n;
    logic        ovf;
  } ev_t;

  ev_t q[$];

  string_detector_ctrl #(.PAT_W(4), .CNT_W(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .frame_len(frame_len), .overlap_en(overlap_en), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy), .done(done),
    .match_pulse(match_pulse), .N(N), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_ev(input bit kind);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: cyc=%0d N=%0d ovf=%0b, want no event",
               kind ? "done" : "match", cyc, N, overflow);
    end else begin
      e = q.pop_front();
      if (e.is_done != kind || e.cyc != cyc || e.n !== N || e.ovf !== overflow) begin
        errors++;
        $display("FAIL event_%s: got kind=%0d cyc=%0d N=%0d ovf=%0b, want kind=%0d cyc=%0d N=%0d ovf=%0b",
                 kind ? "done" : "match", kind, cyc, N, overflow,
                 e.is_done, e.cyc, e.n, e.ovf);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (match_pulse) check_ev(1'b0);
      if (done)        check_ev(1'b1);
    end
  end

  task automatic drain(input string name);
    for (int k = 0; k < 8 && q.size() != 0; k++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: pending=%0d, want 0", name, q.size());
      q.delete();
    end
  endtask

  // stream: MSB-first bits (bit 1 at index len-1); mmask[i-1]: match on bit i
  task automatic run_session(input string name, input logic [3:0] pat,
                             input logic [7:0] len, input logic ovl,
                             input logic [31:0] stream, input logic [31:0] mmask,
                             input bit toggle, input int abort_at);
    logic [3:0] n_exp   = '0;
    logic       ovf_exp = 1'b0;
    bit         aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; pattern = pat; frame_len = len; overlap_en = ovl; bit_valid = 1'b0;
    if (len == 0) q.push_back(ev_t'{1'b1, cyc + 1, 4'd0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after_start"}, {31'd0, busy}, (len == 0) ? 32'd0 : 32'd1);
    for (int i = 1; i <= int'(len) && !aborted; i++) begin
      bit_in = stream[int'(len) - i];
      bit_valid = 1'b1;
      if (mmask[i-1]) begin
        if (n_exp == 4'hF) ovf_exp = 1'b1;
        else n_exp++;
        q.push_back(ev_t'{1'b0, cyc + 1, n_exp, ovf_exp});
      end
      if (i == int'(len)) q.push_back(ev_t'{1'b1, cyc + 1, n_exp, ovf_exp});
      if (i == abort_at) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk({name, "_rst_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_rst_done"}, {31'd0, done}, 32'd0);
        chk({name, "_rst_mp"}, {31'd0, match_pulse}, 32'd0);
        chk({name, "_rst_N"}, {28'd0, N}, 32'd0);
        chk({name, "_rst_ovf"}, {31'd0, overflow}, 32'd0);
        @(negedge clk);
        bit_valid = 1'b0;
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        if (toggle) begin
          bit_valid = 1'b0;
          bit_in = 1'b1;
          if (i == 3) begin
            start = 1'b1; pattern = 4'hF; frame_len = 8'd0;
          end
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    bit_valid = 1'b0;
    drain(name);
    if (!aborted) begin
      @(negedge clk);
      @(negedge clk);
      chk({name, "_held_N"}, {28'd0, N}, {28'd0, n_exp});
      chk({name, "_held_ovf"}, {31'd0, overflow}, {31'd0, ovf_exp});
      chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_idle_done"}, {31'd0, done}, 32'd0);
    end
  endtask

  localparam logic [31:0] S1 = 32'b0110_0110_0001_1011_0001;

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_mp", {31'd0, match_pulse}, 32'd0);
    chk("reset_N", {28'd0, N}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_session("ovl", 4'b0110, 8'd20, 1'b1, S1, 32'h0001_2088, 1'b0, 0);
    run_session("novl", 4'b0110, 8'd20, 1'b0, S1, 32'h0000_2088, 1'b0, 0);
    run_session("zeros", 4'b0000, 8'd20, 1'b1, 32'd0, 32'h000F_FFF8, 1'b0, 0);
    run_session("len0", 4'b1010, 8'd0, 1'b1, 32'd0, 32'd0, 1'b0, 0);
    run_session("toggle", 4'b0110, 8'd8, 1'b1, 32'b0110_0110, 32'h0000_0088, 1'b1, 0);
    run_session("abort", 4'b0110, 8'd20, 1'b1, S1, 32'h0001_2088, 1'b0, 5);
    run_session("rerun", 4'b0110, 8'd20, 1'b1, S1, 32'h0001_2088, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
